// File: rtl/bram_030_slave.sv
// 68030-style block-RAM bus slave: synchronized ASn, address decode, byte-lane writes, wait states, DTACK/DBENn handshake.
// Optional macro BRAM_030_ROM_PROTECT_EN makes longwords below ROM_WORDS read-only.
module bram_030_slave #(
    parameter int unsigned ADDR_BITS   = 12,
    parameter logic [15:0] BASE_HI     = 16'h0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ROM_WORDS   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ADR_OUT,
    input  logic [31:0] DATA_OUT,
    output logic [31:0] DATA_IN,
    input  logic        ASn,
    input  logic        RWn,
    input  logic        UDS,
    input  logic        LDS,
    input  logic        UDS2,
    input  logic        LDS2,
    output logic        DBENn,
    output logic        DTACK
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam int unsigned CNT_W = 3;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LATCH   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [31:0]          mem [0:DEPTH-1];

    logic                 sync1_q, sync2_q;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 rw_q, rw_d;
    logic [3:0]           be_q, be_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [31:0]          data_in_q, data_in_d;
    logic                 dtack_q, dtack_d;
    logic                 dben_n_q, dben_n_d;
    logic                 mem_we;
    logic                 as_sync;
    logic                 rom_hit;
    logic                 unused_ok;

    assign as_sync   = ~sync2_q;
    assign unused_ok = ^{ADR_OUT, ROM_WORDS};

`ifdef BRAM_030_ROM_PROTECT_EN
    assign rom_hit = (32'(addr_q) < ROM_WORDS);
`else
    assign rom_hit = 1'b0;
`endif

    // State register, synchronizer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b1;
            be_q      <= '0;
            wdata_q   <= '0;
            data_in_q <= '0;
            dtack_q   <= 1'b0;
            dben_n_q  <= 1'b1;
        end else begin
            sync1_q   <= ASn;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            data_in_q <= data_in_d;
            dtack_q   <= dtack_d;
            dben_n_q  <= dben_n_d;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        data_in_d = data_in_q;
        mem_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (as_sync && (ADR_OUT[31:16] == BASE_HI)) state_d = S_LATCH;
            end
            S_LATCH: begin
                addr_d  = ADR_OUT[ADDR_BITS+1:2];
                rw_d    = RWn;
                be_d    = {UDS, LDS, UDS2, LDS2};
                wdata_d = DATA_OUT;
                state_d = as_sync ? S_ACCESS : S_IDLE;
            end
            S_ACCESS: begin
                if (rw_q) data_in_d = mem[addr_q];
                else      mem_we    = ~rom_hit;
                cnt_d   = '0;
                state_d = (WAIT_STATES == 0) ? S_ACK : S_WAIT;
            end
            S_WAIT: begin
                if (!as_sync)                                   state_d = S_IDLE;
                else if (cnt_q == CNT_W'(WAIT_STATES - 1))      state_d = S_ACK;
                else                                            cnt_d   = cnt_q + CNT_W'(1);
            end
            S_ACK: begin
                if (!as_sync) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // ACK costs one cycle before DTACK shows, which supplies the read-data register stage.
        dtack_d  = (state_q == S_ACK) && as_sync;
        dben_n_d = !((state_q == S_ACK) && as_sync && rw_q);
    end

    // Byte-lane write port; memory is never reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) mem[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

    assign DATA_IN = data_in_q;
    assign DTACK   = dtack_q;
    assign DBENn   = dben_n_q;

endmodule

// File: tb/tb_bram_030_slave.sv
// Self-checking bench for bram_030_slave: two instances (1 and 7 wait states) against a longword-array reference model.
module tb_bram_030_slave;

    localparam int unsigned MEM_WORDS = 4096;
    localparam int unsigned ROM_W     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr, wdat;
    logic        rwn, uds, lds, uds2, lds2;
    logic        asn1, asn7;
    logic [31:0] din1, din7;
    logic        dben1, dben7, dtack1, dtack7;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mdl1 [int];
    logic [31:0] mdl7 [int];

    always #4 clk = ~clk;

    bram_030_slave #(.ADDR_BITS(12), .BASE_HI(16'h0000), .WAIT_STATES(1), .ROM_WORDS(ROM_W)) u_dut1 (
        .clk(clk), .reset(reset), .ADR_OUT(adr), .DATA_OUT(wdat), .DATA_IN(din1),
        .ASn(asn1), .RWn(rwn), .UDS(uds), .LDS(lds), .UDS2(uds2), .LDS2(lds2),
        .DBENn(dben1), .DTACK(dtack1));

    bram_030_slave #(.ADDR_BITS(12), .BASE_HI(16'h0000), .WAIT_STATES(7), .ROM_WORDS(ROM_W)) u_dut7 (
        .clk(clk), .reset(reset), .ADR_OUT(adr), .DATA_OUT(wdat), .DATA_IN(din7),
        .ASn(asn7), .RWn(rwn), .UDS(uds), .LDS(lds), .UDS2(uds2), .LDS2(lds2),
        .DBENn(dben7), .DTACK(dtack7));

    function automatic logic f_dtack(input int d); return (d == 7) ? dtack7 : dtack1; endfunction
    function automatic logic f_dben(input int d);  return (d == 7) ? dben7  : dben1;  endfunction
    function automatic logic [31:0] f_din(input int d); return (d == 7) ? din7 : din1; endfunction

    task automatic set_asn(input int d, input logic v);
        if (d == 7) asn7 = v; else asn1 = v;
    endtask

    // Reference model: longword array, index wraps mod MEM_WORDS, unselected lanes kept.
    function automatic int lw_index(input logic [31:0] a);
        return int'((a >> 2) % 32'(MEM_WORDS));
    endfunction

    function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
        int idx;
        idx = lw_index(a);
        if (d == 7) return mdl7.exists(idx) ? mdl7[idx] : 32'hxxxx_xxxx;
        return mdl1.exists(idx) ? mdl1[idx] : 32'hxxxx_xxxx;
    endfunction

    task automatic mdl_write(input int d, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int idx;
        logic [31:0] v;
        idx = lw_index(a);
        if (a[31:16] != 16'h0000) return;
`ifdef BRAM_030_ROM_PROTECT_EN
        if (idx < int'(ROM_W)) return;
`endif
        v = mdl_read(d, a);
        for (int b = 0; b < 4; b++) if (be[b]) v[b*8 +: 8] = wd[b*8 +: 8];
        if (d == 7) mdl7[idx] = v; else mdl1[idx] = v;
    endtask

    // One CPU bus cycle; returns what the bus showed: ack latency, data/DBENn at ack, hold stability, release delay.
    task automatic bus_cycle(input int d, input logic [31:0] a, input logic rw, input logic [3:0] be,
                             input logic [31:0] wd, input int hold, input int idle,
                             output logic [31:0] rd, output int lat, output bit held_ok,
                             output logic dben_ack, output int drop, output logic dben_rel);
        int n;
        @(negedge clk);
        adr = a; rwn = rw; {uds, lds, uds2, lds2} = be; wdat = wd;
        set_asn(d, 1'b0);
        lat = -1; n = 0; rd = 32'hxxxx_xxxx; dben_ack = 1'bx; held_ok = 1'b0;
        while (lat < 0 && n < 40) begin
            @(posedge clk); #1; n++;
            if (f_dtack(d) === 1'b1) lat = n - 1;
        end
        if (lat >= 0) begin
            rd = f_din(d); dben_ack = f_dben(d); held_ok = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (f_dtack(d) !== 1'b1 || f_din(d) !== rd || f_dben(d) !== dben_ack) held_ok = 1'b0;
            end
        end
        @(negedge clk);
        set_asn(d, 1'b1);
        drop = -1; n = 0;
        while (drop < 0 && n < 20) begin
            @(posedge clk); #1; n++;
            if (f_dtack(d) === 1'b0) drop = n - 1;
        end
        dben_rel = f_dben(d);
        repeat (idle) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; asn1 = 1'b1; asn7 = 1'b1;
        adr = '0; wdat = '0; rwn = 1'b1; {uds, lds, uds2, lds2} = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dtack1 !== 1'b0) begin n_fail++; $display("FAIL reset_dtack1: got %b expected 0", dtack1); end
        n_checks++; if (dben1 !== 1'b1)  begin n_fail++; $display("FAIL reset_dben1: got %b expected 1", dben1); end
        n_checks++; if (din1 !== 32'h0)  begin n_fail++; $display("FAIL reset_din1: got %h expected 0", din1); end
        n_checks++; if (dtack7 !== 1'b0) begin n_fail++; $display("FAIL reset_dtack7: got %b expected 0", dtack7); end
        n_checks++; if (dben7 !== 1'b1)  begin n_fail++; $display("FAIL reset_dben7: got %b expected 1", dben7); end
        n_checks++; if (din7 !== 32'h0)  begin n_fail++; $display("FAIL reset_din7: got %h expected 0", din7); end
        @(negedge clk); reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read_timing();
        logic [31:0] rd; int lat, drop; bit hok; logic dba, dbr;
        bus_cycle(1, 32'h0000_0010, 1'b0, 4'hF, 32'hDEAD_BEEF, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        n_checks++; if (lat !== 6)   begin n_fail++; $display("FAIL wr_latency: got %0d expected 6", lat); end
        n_checks++; if (dba !== 1'b1) begin n_fail++; $display("FAIL wr_dben_at_ack: got %b expected 1", dba); end
        bus_cycle(1, 32'h0000_0010, 1'b1, 4'hF, 32'h0, 3, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (lat !== 6)   begin n_fail++; $display("FAIL rd_latency: got %0d expected 6", lat); end
        n_checks++; if (rd !== mdl_read(1, 32'h10)) begin n_fail++; $display("FAIL rd_data: got %h expected %h", rd, mdl_read(1, 32'h10)); end
        n_checks++; if (dba !== 1'b0) begin n_fail++; $display("FAIL rd_dben_at_ack: got %b expected 0", dba); end
        n_checks++; if (hok !== 1'b1) begin n_fail++; $display("FAIL rd_hold_stable: got %b expected 1", hok); end
        n_checks++; if (drop !== 2)  begin n_fail++; $display("FAIL rd_release_delay: got %0d expected 2", drop); end
        n_checks++; if (dbr !== 1'b1) begin n_fail++; $display("FAIL rd_dben_release: got %b expected 1", dbr); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat, drop; bit hok; logic dba, dbr;
        bus_cycle(1, 32'h0000_0800, 1'b0, 4'hF, 32'hAABB_CCDD, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(1, 32'h0000_0800, 4'hF, 32'hAABB_CCDD);
        bus_cycle(1, 32'h0000_0800, 1'b0, 4'b0011, 32'h1122_3344, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(1, 32'h0000_0800, 4'b0011, 32'h1122_3344);
        bus_cycle(1, 32'h0000_0800, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== mdl_read(1, 32'h800)) begin n_fail++; $display("FAIL lane_merge: got %h expected %h", rd, mdl_read(1, 32'h800)); end
        bus_cycle(1, 32'h0000_0800, 1'b0, 4'b0000, 32'h5555_5555, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(1, 32'h0000_0800, 4'b0000, 32'h5555_5555);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL nolane_ack: got %0d expected 6", lat); end
        bus_cycle(1, 32'h0000_0800, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== mdl_read(1, 32'h800)) begin n_fail++; $display("FAIL nolane_unchanged: got %h expected %h", rd, mdl_read(1, 32'h800)); end
    endtask

    task automatic test_decode_miss();
        int bad;
        logic [31:0] rd; int lat, drop; bit hok; logic dba, dbr;
        bad = 0;
        @(negedge clk);
        adr = 32'h00AA_0000; rwn = 1'b1; {uds, lds, uds2, lds2} = 4'hF; asn1 = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (dtack1 !== 1'b0 || dben1 !== 1'b1) bad++;
        end
        @(negedge clk); asn1 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL decode_miss: got %0d active cycles expected 0", bad); end
        bus_cycle(1, 32'h0000_0010, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== mdl_read(1, 32'h10) || lat !== 6) begin n_fail++; $display("FAIL after_miss_read: got %h/%0d expected %h/6", rd, lat, mdl_read(1, 32'h10)); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd, v; int lat, drop; bit hok; logic dba, dbr;
        v = $urandom;
        bus_cycle(1, 32'h0000_C014, 1'b0, 4'hF, v, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(1, 32'h0000_C014, 4'hF, v);
        bus_cycle(1, 32'h0000_0017, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== mdl_read(1, 32'h14)) begin n_fail++; $display("FAIL addr_wrap: got %h expected %h", rd, mdl_read(1, 32'h14)); end
    endtask

    task automatic test_rom();
        logic [31:0] rd, expv; int lat, drop; bit hok; logic dba, dbr;
`ifdef BRAM_030_ROM_PROTECT_EN
        bus_cycle(1, 32'h0000_0000, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        expv = rd;
`else
        expv = 32'hFFFF_FFFF;
`endif
        bus_cycle(1, 32'h0000_0000, 1'b0, 4'hF, 32'hFFFF_FFFF, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF);
        n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL rom_write_ack: got %0d expected 6", lat); end
        bus_cycle(1, 32'h0000_0000, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== expv) begin n_fail++; $display("FAIL rom_readback: got %h expected %h", rd, expv); end
    endtask

    task automatic test_abort();
        int bad;
        logic [31:0] rd, v; int lat, drop; bit hok; logic dba, dbr;
        v = $urandom;
        bus_cycle(7, 32'h0000_0040, 1'b0, 4'hF, v, 0, 1, rd, lat, hok, dba, drop, dbr);
        mdl_write(7, 32'h0000_0040, 4'hF, v);
        n_checks++; if (lat !== 12) begin n_fail++; $display("FAIL ws7_latency: got %0d expected 12", lat); end
        bad = 0;
        @(negedge clk);
        adr = 32'h0000_0040; rwn = 1'b1; asn7 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); asn7 = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (dtack7 !== 1'b0 || dben7 !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL abort_no_dtack: got %0d active cycles expected 0", bad); end
        bus_cycle(7, 32'h0000_0040, 1'b1, 4'hF, 32'h0, 1, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== mdl_read(7, 32'h40) || lat !== 12) begin n_fail++; $display("FAIL abort_next_read: got %h/%0d expected %h/12", rd, lat, mdl_read(7, 32'h40)); end
    endtask

    // Reset pulsed at a given cycle into a read; w=5 lands in WAIT, w=7 in ACK.
    task automatic test_reset_midcycle(input int w);
        logic [31:0] rd; int lat, drop; bit hok; logic dba, dbr;
        @(negedge clk);
        adr = 32'h0000_0010; rwn = 1'b1; {uds, lds, uds2, lds2} = 4'hF; asn1 = 1'b0;
        repeat (w) @(posedge clk);
        #2;
        if (w >= 7) begin
            n_checks++; if (dtack1 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_dtack: got %b expected 1", dtack1); end
        end
        reset = 1'b1;
        #1;
        n_checks++; if (dtack1 !== 1'b0 || dben1 !== 1'b1 || din1 !== 32'h0) begin
            n_fail++; $display("FAIL midreset_outputs w%0d: got %b/%b/%h expected 0/1/0", w, dtack1, dben1, din1);
        end
        @(negedge clk); asn1 = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        bus_cycle(1, 32'h0000_0010, 1'b1, 4'hF, 32'h0, 0, 1, rd, lat, hok, dba, drop, dbr);
        n_checks++; if (rd !== mdl_read(1, 32'h10) || lat !== 6) begin n_fail++; $display("FAIL post_reset_read w%0d: got %h/%0d expected %h/6", w, rd, lat, mdl_read(1, 32'h10)); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, v; int lat, drop; bit hok; logic dba, dbr;
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            bus_cycle(1, 32'h0000_0100 + 32'(i * 4), 1'b0, 4'hF, v, 0, 0, rd, lat, hok, dba, drop, dbr);
            mdl_write(1, 32'h0000_0100 + 32'(i * 4), 4'hF, v);
            bus_cycle(1, 32'h0000_0100 + 32'(i * 4), 1'b1, 4'hF, 32'h0, 0, 0, rd, lat, hok, dba, drop, dbr);
            n_checks++; if (rd !== mdl_read(1, 32'h100 + 32'(i * 4)) || lat !== 6) begin
                n_fail++; $display("FAIL b2b_read%0d: got %h/%0d expected %h/6", i, rd, lat, mdl_read(1, 32'h100 + 32'(i * 4)));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] rd, v, a; logic [3:0] be; int lat, drop, k, hold; bit hok; logic dba, dbr;
        for (int i = 0; i < 8; i++) begin
            pool[i] = 32'($urandom_range(ROM_W + 100 + i * 480, ROM_W + 500 + i * 480)) << 2;
            v = $urandom;
            bus_cycle(1, pool[i], 1'b0, 4'hF, v, 0, 1, rd, lat, hok, dba, drop, dbr);
            mdl_write(1, pool[i], 4'hF, v);
        end
        for (int t = 0; t < 50; t++) begin
            k = int'($urandom_range(0, 7));
            a = pool[k] | 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 3)) << 14);
            hold = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                v = $urandom; be = 4'($urandom);
                bus_cycle(1, a, 1'b0, be, v, hold, 1, rd, lat, hok, dba, drop, dbr);
                mdl_write(1, a, be, v);
                n_checks++; if (lat !== 6 || dba !== 1'b1 || hok !== 1'b1) begin
                    n_fail++; $display("FAIL rand_write%0d: got lat %0d dben %b hold %b expected 6/1/1", t, lat, dba, hok);
                end
            end else begin
                bus_cycle(1, a, 1'b1, 4'hF, 32'h0, hold, 1, rd, lat, hok, dba, drop, dbr);
                n_checks++; if (rd !== mdl_read(1, a) || lat !== 6 || dba !== 1'b0 || hok !== 1'b1 || drop !== 2) begin
                    n_fail++; $display("FAIL rand_read%0d: got %h lat %0d dben %b hold %b drop %0d expected %h/6/0/1/2",
                                       t, rd, lat, dba, hok, drop, mdl_read(1, a));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_timing();
        test_byte_lanes();
        test_decode_miss();
        test_wrap();
        test_rom();
        test_abort();
        test_reset_midcycle(5);
        test_reset_midcycle(7);
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_030_slave.md
BRAM_030_SLAVE -- requirements
Module: bram_030_slave

Interface
REQ-001 Parameter ADDR_BITS, default 12: longword address width; memory holds 2^ADDR_BITS x 32 bits.
REQ-002 Parameter BASE_HI, default 16'h0000: value ADR_OUT[31:16] must equal to select this slave.
REQ-003 Parameter WAIT_STATES, default 1, range 0-7: extra clk cycles inserted before DTACK.
REQ-004 Parameter ROM_WORDS, default 256: size of the write-protected low region, in longwords.
REQ-005 clk  in  1  single clock, 114 MHz domain; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 ADR_OUT  in  32  CPU byte address; longword index is ADR_OUT[ADDR_BITS+1:2].
REQ-008 DATA_OUT  in  32  CPU write data.
REQ-009 DATA_IN  out  32  read data to CPU.
REQ-010 ASn  in  1  CPU address strobe, active-low, asynchronous to clk.
REQ-011 RWn  in  1  1 = read, 0 = write.
REQ-012 UDS, LDS, UDS2, LDS2  in  1 each  active-high byte-lane strobes for bits [31:24], [23:16], [15:8], [7:0].
REQ-013 DBENn  out  1  active-low data buffer enable; low only while read data is driven.
REQ-014 DTACK  out  1  active-high cycle acknowledge.

Function
REQ-015 ASn SHALL pass through a 2-flop synchronizer; "as" denotes synchronized ASn low.
REQ-016 FSM states: IDLE, LATCH, ACCESS, WAIT, ACK, RELEASE.
REQ-017 IDLE -> LATCH when as = 1 and ADR_OUT[31:16] = BASE_HI; a decode miss stays IDLE with DTACK low.
REQ-018 LATCH SHALL register the address index, RWn, the four strobes and DATA_OUT; the FSM then goes to ACCESS.
REQ-019 ACCESS, read: registered RAM read, so data is valid in DATA_IN one cycle later. ACCESS, write: each enabled byte lane is written, and disabled lanes are unchanged.
REQ-020 WAIT SHALL count WAIT_STATES cycles; with WAIT_STATES = 0 it is skipped.
REQ-021 ACK SHALL assert DTACK and, for a read, drive DBENn low. Both are held, with DATA_IN stable, until as = 0; then RELEASE.
REQ-022 RELEASE SHALL deassert DTACK, drive DBENn high and return to IDLE on the next cycle.
REQ-023 Latency from the first clk edge seeing ASn low to DTACK high is 5 + WAIT_STATES cycles for both read and write (2 sync, LATCH, ACCESS, read-data register/WAIT).
REQ-024 A write with all strobes 0 SHALL change no memory and SHALL still be acknowledged.
REQ-025 Abort: if as = 0 in LATCH or WAIT, the FSM goes to IDLE with no DTACK. A write already issued in ACCESS is kept.
REQ-026 A new cycle SHALL NOT start until RELEASE has completed (no back-to-back without an ASn-high interval).
REQ-027 The longword address wraps modulo 2^ADDR_BITS; ADR_OUT[1:0] is ignored.

Reset
REQ-028 While reset is high: FSM = IDLE, DTACK = 0, DBENn = 1, DATA_IN = 0, synchronizer flops = 1 (ASn inactive), WAIT counter = 0.
REQ-029 Reset asserted mid-cycle SHALL abort the cycle immediately. Memory contents are not cleared.

Configuration
REQ-030 Macro BRAM_030_ROM_PROTECT_EN defined: writes to longword index < ROM_WORDS are discarded but still receive DTACK. Undefined: the whole array is writable.

Verification
REQ-031 Read, WAIT_STATES = 1, mem[4] = 32'hDEADBEEF, ADR_OUT = 32'h00000010, ASn low -> DTACK high 6 cycles later, DATA_IN = 32'hDEADBEEF, DBENn = 0, DTACK drops 2 cycles after ASn rises.
REQ-032 Write 32'h11223344 to 32'h00000800 with only UDS2 and LDS2, prior value 32'hAABBCCDD -> readback 32'hAABB3344.
REQ-033 ADR_OUT = 32'h00AA0000, BASE_HI = 0 -> DTACK stays 0 for 50 cycles and the FSM remains IDLE.
REQ-034 BRAM_030_ROM_PROTECT_EN defined, write 32'hFFFFFFFF to 32'h00000000 -> DTACK asserted, readback unchanged. Macro undefined -> readback 32'hFFFFFFFF.
REQ-035 ASn released 3 cycles after assertion with WAIT_STATES = 7 -> no DTACK, FSM back to IDLE, the next read completes normally.
REQ-036 Reset pulsed during WAIT -> DTACK = 0 and DBENn = 1 within the same cycle, and the next cycle after reset release succeeds.
